// File: rtl/morse_encoder.sv
// Plays a 10-bit Morse word on a single LED, MSB symbol pair first.
// Symbol encoding: 00 none, 01 dot, 11 line, 10 reserved (terminates).
module morse_encoder #(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned DOT_UNITS   = 1,
  parameter int unsigned LINE_UNITS  = 3,
  parameter int unsigned GAP_UNITS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] code,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [2:0] sym_count
);

  localparam logic [31:0] DOT_LOAD  = 32'(DOT_UNITS * UNIT_CYCLES);
  localparam logic [31:0] LINE_LOAD = 32'(LINE_UNITS * UNIT_CYCLES);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_UNITS * UNIT_CYCLES);

  typedef enum logic [2:0] {IDLE, SYM, ON, GAP, DONE} state_t;

  state_t      state, state_next;
  logic [9:0]  shreg, shreg_next;
  logic [31:0] timer, timer_next;
  logic [2:0]  sym_count_next;
  logic        led_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      timer     <= '0;
      sym_count <= '0;
      led       <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      timer     <= timer_next;
      sym_count <= sym_count_next;
      led       <= led_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    timer_next     = timer;
    sym_count_next = sym_count;
    led_next       = led;

    unique case (state)
      IDLE: begin
        led_next = 1'b0;
        if (start) begin
          shreg_next     = code;
          sym_count_next = '0;
          state_next     = SYM;
        end
      end
      SYM: begin
        if (sym_count == 3'd5) begin
          state_next = DONE;
        end else begin
          unique case (shreg[9:8])
            2'b01: begin
              timer_next = DOT_LOAD;
              led_next   = 1'b1;
              state_next = ON;
            end
            2'b11: begin
              timer_next = LINE_LOAD;
              led_next   = 1'b1;
              state_next = ON;
            end
            default: state_next = DONE;
          endcase
        end
      end
      ON: begin
        if (timer <= 32'd1) begin
          led_next   = 1'b0;
          timer_next = GAP_LOAD;
          state_next = GAP;
        end else begin
          timer_next = timer - 32'd1;
        end
      end
      GAP: begin
        if (timer <= 32'd1) begin
          timer_next     = '0;
          shreg_next     = shreg << 2;
          sym_count_next = sym_count + 3'd1;
          state_next     = SYM;
        end else begin
          timer_next = timer - 32'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4; cycle 0 is the cycle
// in which start is presented, cycle n is sampled just after the n-th edge.
module tb_morse_encoder;
  localparam int UNIT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] code;
  logic       led, busy, done;
  logic [2:0] sym_count;

  int vectors = 0;
  int miscompares = 0;

  logic       led_tr  [0:127];
  logic       done_tr [0:127];
  logic       busy_tr [0:127];
  logic [2:0] cnt_tr  [0:127];

  morse_encoder #(.UNIT_CYCLES(UNIT)) dut (
    .clock(clock), .reset(reset), .start(start), .code(code),
    .led(led), .busy(busy), .done(done), .sym_count(sym_count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Presents start in cycle 0, records cycles 1..n. Start stays high through
  // cycle hold_until and is pulsed again (with pert_code) in pert_cycle.
  task automatic capture(input int n, input int hold_until, input int pert_cycle,
                         input logic [9:0] pert_code);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      tick();
      led_tr[c]  = led;
      done_tr[c] = done;
      busy_tr[c] = busy;
      cnt_tr[c]  = sym_count;
      start = (c <= hold_until) || (c == pert_cycle);
      if (c == pert_cycle) code = pert_code;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    code  = 10'b11_11_11_11_11;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({led, busy, done, sym_count} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_state cycle %0d: got led=%b busy=%b done=%b cnt=%0d want all 0",
                 i, led, busy, done, sym_count);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({led, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_start_ignored cycle %0d: got led=%b busy=%b want 0 0", i, led, busy);
      end
    end
  endtask

  task automatic test_word_a(input string name, input int pert_cycle);
    logic el, ed, eb;
    code = 10'b01_11_01_00_00;
    capture(45, 0, pert_cycle, 10'b11_11_11_11_11);
    for (int c = 1; c <= 45; c++) begin
      el = (c >= 2 && c <= 5) || (c >= 11 && c <= 22) || (c >= 28 && c <= 31);
      ed = (c == 37);
      eb = (c <= 37);
      vectors++;
      if (led_tr[c] !== el) begin
        miscompares++;
        $display("FAIL %s led cycle %0d: got %b want %b", name, c, led_tr[c], el);
      end
      vectors++;
      if (done_tr[c] !== ed) begin
        miscompares++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, c, done_tr[c], ed);
      end
      vectors++;
      if (busy_tr[c] !== eb) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy_tr[c], eb);
      end
    end
    vectors++;
    if (cnt_tr[10] !== 3'd1) begin
      miscompares++;
      $display("FAIL %s sym_count after first gap: got %0d want 1", name, cnt_tr[10]);
    end
    vectors++;
    if (cnt_tr[45] !== 3'd3) begin
      miscompares++;
      $display("FAIL %s sym_count final: got %0d want 3", name, cnt_tr[45]);
    end
  endtask

  task automatic test_full_word;
    logic el;
    code = 10'b11_11_11_11_11;
    capture(90, 0, -1, 10'b0);
    for (int c = 1; c <= 90; c++) begin
      el = 1'b0;
      for (int i = 0; i < 5; i++)
        if (c >= 2 + 17 * i && c <= 13 + 17 * i) el = 1'b1;
      vectors++;
      if (led_tr[c] !== el) begin
        miscompares++;
        $display("FAIL full_word led cycle %0d: got %b want %b", c, led_tr[c], el);
      end
      vectors++;
      if (done_tr[c] !== (c == 87)) begin
        miscompares++;
        $display("FAIL full_word done cycle %0d: got %b want %b", c, done_tr[c], c == 87);
      end
    end
    vectors++;
    if (cnt_tr[88] !== 3'd5) begin
      miscompares++;
      $display("FAIL full_word sym_count: got %0d want 5", cnt_tr[88]);
    end
  endtask

  task automatic test_terminator(input string name, input logic [9:0] word);
    code = word;
    capture(5, 0, -1, 10'b0);
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if ({led_tr[c], done_tr[c], busy_tr[c]} !== {1'b0, c == 2, c <= 2}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got led=%b done=%b busy=%b want 0 %b %b",
                 name, c, led_tr[c], done_tr[c], busy_tr[c], c == 2, c <= 2);
      end
    end
    vectors++;
    if (cnt_tr[5] !== 3'd0) begin
      miscompares++;
      $display("FAIL %s sym_count: got %0d want 0", name, cnt_tr[5]);
    end
  endtask

  task automatic test_back_to_back;
    logic el, ed, eb;
    code = 10'b01_00_00_00_00;
    capture(27, 12, -1, 10'b0);
    for (int c = 1; c <= 27; c++) begin
      el = (c >= 2 && c <= 5) || (c >= 14 && c <= 17);
      ed = (c == 11) || (c == 23);
      eb = !(c == 12 || c >= 24);
      vectors++;
      if ({led_tr[c], done_tr[c], busy_tr[c]} !== {el, ed, eb}) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got led=%b done=%b busy=%b want %b %b %b",
                 c, led_tr[c], done_tr[c], busy_tr[c], el, ed, eb);
      end
    end
  endtask

  task automatic test_reset_mid;
    code = 10'b01_11_01_00_00;
    capture(13, 0, -1, 10'b0);
    vectors++;
    if (led_tr[13] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid led before reset: got %b want 1", led_tr[13]);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({led, busy, done, sym_count} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid after reset: got led=%b busy=%b done=%b cnt=%0d want all 0",
               led, busy, done, sym_count);
    end
    reset = 1'b0;
    code  = 10'b01_00_00_00_00;
    capture(14, 0, -1, 10'b0);
    for (int c = 1; c <= 14; c++) begin
      vectors++;
      if ({led_tr[c], done_tr[c]} !== {c >= 2 && c <= 5, c == 11}) begin
        miscompares++;
        $display("FAIL reset_mid restart cycle %0d: got led=%b done=%b want %b %b",
                 c, led_tr[c], done_tr[c], c >= 2 && c <= 5, c == 11);
      end
    end
    vectors++;
    if (cnt_tr[14] !== 3'd1) begin
      miscompares++;
      $display("FAIL reset_mid restart sym_count: got %0d want 1", cnt_tr[14]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    code  = '0;
    test_reset();
    test_word_a("word_a", -1);
    test_full_word();
    test_terminator("empty_word", 10'b0);
    test_terminator("reserved_sym", 10'b10_01_00_00_00);
    test_word_a("perturbed", 15);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Transmits a 10-bit Morse code word as timed on/off pulses on a single LED output, one symbol at a time, MSB pair first. It uses the same 2-bit symbol encoding as the player code words: 00 none, 01 dot, 11 line. It sits on the player1 side of the game and plays player1's code back to player2 before and after a round, as the output-direction counterpart of `morse_decoder`.

## Interface

Parameters:
- UNIT_CYCLES, 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz); must be ≥ 1.
- DOT_UNITS, 1: LED-on duration of a dot, in units.
- LINE_UNITS, 3: LED-on duration of a line, in units.
- GAP_UNITS, 1: LED-off gap after every transmitted symbol, in units.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request transmission of `code`; sampled only in IDLE.
- code  in  10  symbol word; symbol 0 = [9:8], symbol 4 = [1:0].
- led  out  1  registered Morse output; 1 = on.
- busy  out  1  1 in every state except IDLE.
- done  out  1  one-cycle pulse when transmission ends.
- sym_count  out  3  number of symbols fully transmitted (on + gap) in the current or last word, 0–5.

## Operation

- States: IDLE, SYM, ON, GAP, DONE.
- IDLE: `led`=0, `busy`=0. If `start`=1, then `shreg`←`code`, `sym_count`←0, and the next state is SYM.
- SYM: decode `shreg[9:8]`.
  - 01: load the timer with DOT_UNITS·UNIT_CYCLES, set `led`←1, go to ON.
  - 11: load the timer with LINE_UNITS·UNIT_CYCLES, set `led`←1, go to ON.
  - 00 or 10: end of word; go to DONE. 10 is reserved and is always treated as a terminator.
  - If `sym_count`=5, go to DONE regardless of `shreg`.
- ON: the timer decrements each cycle. On the last cycle (timer=1): `led`←0, load the timer with GAP_UNITS·UNIT_CYCLES, go to GAP.
- GAP: the timer decrements each cycle. On the last cycle: `shreg`←`shreg`<<2, `sym_count`←`sym_count`+1, go to SYM.
- DONE: `done`=1 for this single cycle, then go to IDLE. `sym_count` holds its value until the next start.
- Timer: 32-bit unsigned down-counter. Products are computed at elaboration as constants; they are not computed in hardware.
- Once `start` is accepted, the word is latched. Changes on `code` while busy have no effect.
- `start` while busy is ignored and not queued.
- `start` held high through DONE → IDLE is accepted on the first IDLE cycle, giving back-to-back transmission.

## Timing

- Reset values: state IDLE, `led` 0, `busy` 0, `done` 0, `sym_count` 0, `shreg` 0, timer 0.
- Reset asserted mid-transmission: on the next edge everything returns to its reset value and `led` drops immediately.
- Reset and `start` in the same cycle: reset wins.
- Latency:
  - `start` sampled at edge k gives SYM during cycle k+1.
  - `led` rises at edge k+1, so it is high from cycle k+2.
- Per symbol:
  - 1 SYM cycle.
  - ON for exactly DOT_UNITS·UNIT_CYCLES or LINE_UNITS·UNIT_CYCLES cycles.
  - GAP for exactly GAP_UNITS·UNIT_CYCLES cycles.
- Terminating SYM takes 1 cycle, then DONE takes 1 cycle with `done`=1. `busy` falls in the cycle after DONE.
- Empty word (code=0): start at edge k gives SYM in cycle k+1, DONE in cycle k+2, and IDLE in cycle k+3. `led` never rises and `sym_count` stays 0.
- Full 5-symbol word: after the fifth GAP, `sym_count`=5. SYM then goes to DONE without inspecting `shreg`, which is 0 after the shifts.

## Test plan

Use UNIT_CYCLES=4 and default units.
- After reset, `led`=`busy`=`done`=0 and `sym_count`=0. Holding `start`=1 during reset produces no transmission.
- code=10'b01_11_01_00_00, start at cycle 0 → expected response:
  - `led` high in cycles 2–5, 11–22 and 28–31.
  - `done`=1 in cycle 37 and `busy`=0 from cycle 38.
  - `sym_count`=3.
- code=10'b11_11_11_11_11 → 5 line pulses of 12 cycles each, separated by 5-cycle off periods (4 GAP + 1 SYM). `done` pulses once, with `sym_count`=5.
- code=0 → `led` stays 0 and `done` pulses in cycle 2. code=10'b10_01_00_00_00 → identical: the reserved symbol terminates the word.
- code changes and `start` pulses in the middle of a line → the waveform is unchanged from the unperturbed run and no second transmission occurs. Holding `start` high continuously gives back-to-back words, with the second SYM one cycle after the first IDLE.
- Reset asserted during the second symbol's ON phase → `led`=0, `busy`=0 and `sym_count`=0 on the next cycle. A new `start` then transmits correctly from symbol 0.
